// File: rtl/fifo_multi_reader.sv
// fifo_multi_reader: round-robin read-side controller draining NUM_CH
// non-FWFT FIFOs into one tagged stream, periodic or continuous.
module fifo_multi_reader #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int CNTR_W  = 4,
  parameter int BURST_W = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ENABLE,
  input  logic                        MODE,
  input  logic [CNTR_W-1:0]           PERIOD,
  input  logic [BURST_W-1:0]          BURST_LEN,
  input  logic [NUM_CH-1:0]           EMPTY,
  input  logic [NUM_CH*DATA_W-1:0]    DIN,
  output logic [NUM_CH-1:0]           RD_EN,
  output logic [DATA_W-1:0]           DOUT,
  output logic                        DOUT_VALID,
  output logic [$clog2(NUM_CH)-1:0]   DOUT_CH,
  output logic                        MISSED_TICK,
  output logic                        BUSY
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, WAIT, ARB, BURST} state_t;

  state_t              state_q, state_d;
  logic [CNTR_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0]  beat_q, beat_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic                missed_q, missed_d;
  logic                rd_vld_q, rd_vld_d;
  logic [CH_W-1:0]     rd_ch_q, rd_ch_d;
  logic                dv_q, dv_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [CH_W-1:0]     dch_q, dch_d;

  logic [DATA_W-1:0]   din_a [NUM_CH];
  logic                found;
  logic [CH_W-1:0]     winner;
  logic [CH_W:0]       sum;
  logic [BURST_W-1:0]  len_m1;
  logic                rd;
  logic [NUM_CH-1:0]   rd_en;
  state_t              leave_st;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_din
    assign din_a[g] = DIN[g*DATA_W +: DATA_W];
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      sum = {1'b0, last_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH))
        sum = sum - (CH_W+1)'(NUM_CH);
      if (!found && !EMPTY[sum[CH_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[CH_W-1:0];
      end
    end
  end

  // Next-state, counters and read strobe
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    grant_d  = grant_q;
    last_d   = last_q;
    missed_d = 1'b0;
    rd_en    = '0;
    rd       = 1'b0;
    len_m1   = (BURST_LEN == '0) ? '0
             : BURST_LEN - 1'b1;
    leave_st = ENABLE ? (MODE ? ARB : WAIT)
             : IDLE;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ENABLE)
          state_d = MODE ? ARB : WAIT;
      end
      WAIT: begin
        if (!ENABLE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PERIOD) begin
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB: begin
        if (found) begin
          grant_d = winner;
          beat_d  = '0;
          state_d = BURST;
        end else begin
          missed_d = ~MODE;
          cnt_d    = '0;
          state_d  = leave_st;
        end
      end
      BURST: begin
        rd = ~EMPTY[grant_q] & ~RST;
        if (rd) begin
          rd_en[grant_q] = 1'b1;
          beat_d         = beat_q + 1'b1;
        end
        if (EMPTY[grant_q] || (rd && beat_q == len_m1)) begin
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = leave_st;
        end
      end
    endcase
  end

  // Two-stage capture: strobe -> FIFO data -> tagged output
  always_comb begin
    rd_vld_d = |rd_en;
    rd_ch_d  = rd_vld_d ? grant_q : rd_ch_q;
    dv_d     = rd_vld_q;
    dout_d   = rd_vld_q ? din_a[rd_ch_q] : dout_q;
    dch_d    = rd_vld_q ? rd_ch_q : dch_q;
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      grant_q  <= '0;
      last_q   <= CH_W'(NUM_CH - 1);
      missed_q <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_ch_q  <= '0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
      dch_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      missed_q <= missed_d;
      rd_vld_q <= rd_vld_d;
      rd_ch_q  <= rd_ch_d;
      dv_q     <= dv_d;
      dout_q   <= dout_d;
      dch_q    <= dch_d;
    end
  end

  assign RD_EN       = rd_en;
  assign DOUT        = dout_q;
  assign DOUT_VALID  = dv_q;
  assign DOUT_CH     = dch_q;
  assign MISSED_TICK = missed_q;
  assign BUSY        = (state_q != IDLE) | rd_vld_q | dv_q;

endmodule
